// File: rtl/controlador_interrupciones.sv
// Eight-line interrupt controller: rising-edge capture, maskable pending bits,
// fixed highest-index-wins priority and a non-nesting request/ack/reti handshake.
module controlador_interrupciones #(
  parameter int unsigned       NUM_IRQ  = 8,
  parameter int unsigned       ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] VEC_BASE = 10'h3F0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_IRQ-1:0] interrupcion_i,
  input  logic               mascara_we_i,
  input  logic [NUM_IRQ-1:0] mascara_in_i,
  input  logic               ack_i,
  input  logic               reti_i,
  output logic               irq_req_o,
  output logic [2:0]         irq_id_o,
  output logic [ADDR_W-1:0]  irq_vector_o,
  output logic [NUM_IRQ-1:0] pendientes_o,
  output logic               en_servicio_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [2:0]         irq_id_q, irq_id_d;
  logic               irq_req_q, irq_req_d;
  logic               en_serv_q, en_serv_d;

  logic [NUM_IRQ-1:0] rise_s;
  logic [NUM_IRQ-1:0] elig_s;
  logic [NUM_IRQ-1:0] clr_s;

  // Highest set index wins; later iterations overwrite earlier ones.
  function automatic logic [2:0] winner(input logic [NUM_IRQ-1:0] v);
    logic [2:0] w;
    w = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w = v[i] ? 3'(i) : w;
    end
    return w;
  endfunction

  assign rise_s = interrupcion_i & ~prev_q;
  assign elig_s = pend_q & ~mask_q;

  // Handshake FSM: winner is latched on entry to REQ and held until ack.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr_s    = '0;
    case (state_q)
      ST_IDLE: begin
        if (elig_s != '0) begin
          state_d  = ST_REQ;
          irq_id_d = winner(elig_s);
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (ack_i) begin
          state_d         = ST_SERV;
          clr_s[irq_id_q] = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERV: begin
        if (reti_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending/mask/edge bookkeeping; a fresh edge beats the ack clear.
  always_comb begin
    pend_d    = (pend_q & ~clr_s) | rise_s;
    prev_d    = interrupcion_i;
    irq_req_d = (state_d == ST_REQ);
    en_serv_d = (state_d == ST_SERV);
    if (mascara_we_i) begin
      mask_d = mascara_in_i;
    end else begin
      mask_d = mask_q;
    end
  end

  // State register; prev resets high so lines already asserted do not fire.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      mask_q    <= '0;
      prev_q    <= '1;
      irq_id_q  <= 3'd0;
      irq_req_q <= 1'b0;
      en_serv_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      prev_q    <= prev_d;
      irq_id_q  <= irq_id_d;
      irq_req_q <= irq_req_d;
      en_serv_q <= en_serv_d;
    end
  end

  assign irq_req_o     = irq_req_q;
  assign irq_id_o      = irq_id_q;
  assign irq_vector_o  = VEC_BASE + ADDR_W'(irq_id_q);
  assign pendientes_o  = pend_q;
  assign en_servicio_o = en_serv_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Directed + random bench for controlador_interrupciones against an event-level
// reference model (pending set, grant index, in-handler flag).
module tb_controlador_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] intr;
  logic       we;
  logic [7:0] min;
  logic       ack;
  logic       reti;
  logic       irq_req;
  logic [2:0] irq_id;
  logic [9:0] irq_vector;
  logic [7:0] pendientes;
  logic       en_servicio;

  always #5 clk = ~clk;

  controlador_interrupciones dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .interrupcion_i (intr),
    .mascara_we_i   (we),
    .mascara_in_i   (min),
    .ack_i          (ack),
    .reti_i         (reti),
    .irq_req_o      (irq_req),
    .irq_id_o       (irq_id),
    .irq_vector_o   (irq_vector),
    .pendientes_o   (pendientes),
    .en_servicio_o  (en_servicio)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_mask = 8'h00;
  logic [7:0] m_prev = 8'hFF;
  int         m_id   = 0;
  bit         m_req  = 1'b0;
  bit         m_serv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [7:0] rise;
    logic [7:0] elig;
    rise = intr & ~m_prev;
    elig = m_pend & ~m_mask;
    if (reset) begin
      m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'hFF;
      m_id = 0; m_req = 1'b0; m_serv = 1'b0;
    end else begin
      if (m_req) begin
        if (ack) begin
          m_pend[m_id] = 1'b0;
          m_req  = 1'b0;
          m_serv = 1'b1;
        end
      end else if (m_serv) begin
        if (reti) m_serv = 1'b0;
      end else begin
        for (int i = 0; i < 8; i++) begin
          if (elig[i]) begin
            m_id  = i;
            m_req = 1'b1;
          end
        end
      end
      m_pend = m_pend | rise;
      if (we) m_mask = min;
      m_prev = intr;
    end
  endtask

  task automatic check_all();
    chk("irq_req", 32'(irq_req), 32'(m_req));
    chk("en_servicio", 32'(en_servicio), 32'(m_serv));
    chk("irq_id", 32'(irq_id), 32'(m_id));
    chk("irq_vector", 32'(irq_vector), 32'h3F0 + 32'(m_id));
    chk("pendientes", 32'(pendientes), 32'(m_pend));
  endtask

  task automatic cyc(input logic [7:0] i_in, input logic i_ack, input logic i_reti,
                     input logic i_we, input logic [7:0] i_m, input logic i_rst);
    intr = i_in; ack = i_ack; reti = i_reti; we = i_we; min = i_m; reset = i_rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    intr = 8'h00; ack = 1'b0; reti = 1'b0; we = 1'b0; min = 8'h00; reset = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("reset_req", 32'(irq_req), 32'd0);
    chk("reset_pend", 32'(pendientes), 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // 1 single request
    cyc(8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_pend", 32'(pendientes), 32'h01);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_req", 32'(irq_req), 32'd1);
    chk("t1_vec", 32'(irq_vector), 32'h3F0);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_serv", 32'(en_servicio), 32'd1);
    chk("t1_pend0", 32'(pendientes), 32'h00);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t1_noreq", 32'(irq_req), 32'd0);

    // 2 priority 7,4,0; ack and reti together in REQ acts as ack only
    cyc(8'h91, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_pend91", 32'(pendientes), 32'h91);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_vec7", 32'(irq_vector), 32'h3F7);
    cyc(8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("t2_pend11", 32'(pendientes), 32'h11);
    chk("t2_serv", 32'(en_servicio), 32'd1);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_id4", 32'(irq_id), 32'd4);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_pend01", 32'(pendientes), 32'h01);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_id0", 32'(irq_id), 32'd0);
    chk("t2_req0", 32'(irq_req), 32'd1);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t2_pend00", 32'(pendientes), 32'h00);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 3 mask
    cyc(8'h00, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0);
    cyc(8'hA0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_id5", 32'(irq_id), 32'd5);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_pend80", 32'(pendientes), 32'h80);
    cyc(8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t3_id7", 32'(irq_id), 32'd7);
    chk("t3_req7", 32'(irq_req), 32'd1);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 4 no nesting
    cyc(8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h40, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_pend40", 32'(pendientes), 32'h40);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_noreq", 32'(irq_req), 32'd0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t4_id6", 32'(irq_id), 32'd6);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 5 ack collision
    cyc(8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h08, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_pend08", 32'(pendientes), 32'h08);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t5_id3", 32'(irq_id), 32'd3);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // 6 reset mid-REQ with line 2 held
    cyc(8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_req", 32'(irq_req), 32'd1);
    cyc(8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("t6_rst_req", 32'(irq_req), 32'd0);
    cyc(8'h04, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h04, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    cyc(8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_held_pend", 32'(pendientes), 32'h00);
    chk("t6_held_serv", 32'(en_servicio), 32'd0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h04, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("t6_id2", 32'(irq_id), 32'd2);
    cyc(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

    // random phase
    for (int n = 0; n < 600; n++) begin
      logic [7:0] r_in;
      r_in = ($urandom_range(0, 2) == 0) ? 8'($urandom) : intr & 8'($urandom);
      cyc(r_in,
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 15) == 0),
          8'($urandom) & 8'($urandom),
          1'($urandom_range(0, 99) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
